// File: rtl/mbist_response_checker.sv
// rtl/mbist_response_checker.sv - MBIST read-side response analyzer
// Delays expected bit/address by RD_LAT, compares against rd_data, reports fail/count/first address/verdict.
module mbist_response_checker #(
  parameter int ADDR   = 8,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             cmp_en,
  input  logic [ADDR-1:0]  cmp_addr,
  input  logic             exp_data,
  input  logic             rd_data,
  input  logic             test_done,
  output logic             fail,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             first_fail_valid,
  output logic [ADDR-1:0]  first_fail_addr,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   r_state;
  logic                     r_done;
  logic [RD_LAT-1:0]        r_vld;
  logic [RD_LAT-1:0]        r_exp;
  logic [RD_LAT-1:0]        r_tdone;
  logic [RD_LAT-1:0][ADDR-1:0] r_addr;
  logic                     r_fail;
  logic [CNT_W-1:0]         r_fail_cnt;
  logic                     r_ffv;
  logic [ADDR-1:0]          r_ffa;

  logic                     w_in_vld;
  logic                     w_in_tdone;
  logic                     w_last_vld;
  logic                     w_last_exp;
  logic                     w_last_tdone;
  logic [ADDR-1:0]          w_last_addr;
  logic                     w_mismatch;
  logic                     w_cnt_sat;

  // Once the verdict is in, nothing new is allowed into the pipeline.
  assign w_in_vld     = cmp_en & ~r_done;
  assign w_in_tdone   = test_done & ~r_done;
  assign w_last_vld   = r_vld[RD_LAT-1];
  assign w_last_exp   = r_exp[RD_LAT-1];
  assign w_last_tdone = r_tdone[RD_LAT-1];
  assign w_last_addr  = r_addr[RD_LAT-1];
  assign w_mismatch   = w_last_vld & (rd_data ^ w_last_exp);
  assign w_cnt_sat    = &r_fail_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= '0;
      r_exp   <= '0;
      r_tdone <= '0;
      r_addr  <= '0;
    end else if (clear) begin
      r_vld   <= '0;
      r_exp   <= '0;
      r_tdone <= '0;
      r_addr  <= '0;
    end else begin
      r_vld[0]   <= w_in_vld;
      r_exp[0]   <= exp_data;
      r_tdone[0] <= w_in_tdone;
      r_addr[0]  <= cmp_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i]   <= r_vld[i-1];
        r_exp[i]   <= r_exp[i-1];
        r_tdone[i] <= r_tdone[i-1];
        r_addr[i]  <= r_addr[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail     <= 1'b0;
      r_fail_cnt <= '0;
      r_ffv      <= 1'b0;
      r_ffa      <= '0;
    end else if (clear) begin
      r_fail     <= 1'b0;
      r_fail_cnt <= '0;
      r_ffv      <= 1'b0;
      r_ffa      <= '0;
    end else if (w_mismatch) begin
      r_fail <= 1'b1;
      if (!w_cnt_sat) begin
        r_fail_cnt <= r_fail_cnt + CNT_W'(1);
      end
      // Only the very first failing address is kept for diagnosis.
      if (!r_ffv) begin
        r_ffv <= 1'b1;
        r_ffa <= w_last_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else if (clear) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_last_tdone) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (cmp_en) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_last_tdone) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_done <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign fail             = r_fail;
  assign fail_cnt         = r_fail_cnt;
  assign first_fail_valid = r_ffv;
  assign first_fail_addr  = r_ffa;
  assign done             = r_done;
  assign pass             = r_done & ~r_fail;

endmodule

// File: tb/tb_mbist_response_checker.sv
// tb/tb_mbist_response_checker.sv - directed bench for mbist_response_checker
// Drives two instances (RD_LAT=1/CNT_W=8 and RD_LAT=3/CNT_W=3) from one stimulus and checks both against a history model.
module tb_mbist_response_checker;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       cmp_en;
  logic [7:0] cmp_addr;
  logic       exp_data;
  logic       rd_a;
  logic       rd_b;
  logic       test_done;

  logic       fail_a, ffv_a, done_a, pass_a;
  logic [7:0] cnt_a, ffa_a;
  logic       fail_b, ffv_b, done_b, pass_b;
  logic [2:0] cnt_b;
  logic [7:0] ffa_b;

  mbist_response_checker #(.ADDR(8), .RD_LAT(1), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .cmp_en(cmp_en), .cmp_addr(cmp_addr),
    .exp_data(exp_data), .rd_data(rd_a), .test_done(test_done),
    .fail(fail_a), .fail_cnt(cnt_a), .first_fail_valid(ffv_a), .first_fail_addr(ffa_a),
    .done(done_a), .pass(pass_a)
  );

  mbist_response_checker #(.ADDR(8), .RD_LAT(3), .CNT_W(3)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .cmp_en(cmp_en), .cmp_addr(cmp_addr),
    .exp_data(exp_data), .rd_data(rd_b), .test_done(test_done),
    .fail(fail_b), .fail_cnt(cnt_b), .first_fail_valid(ffv_b), .first_fail_addr(ffa_b),
    .done(done_b), .pass(pass_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, req);
  endtask

  // Model: every issued read is remembered by issue cycle; the verdict for
  // cycle n looks up the read issued LAT cycles earlier.
  int  cyc = 0;
  int  flush_cyc = -1;
  bit  rv [0:1][0:1023];
  bit  rt [0:1][0:1023];
  bit  [7:0] ra [0:1023];
  bit  re [0:1023];
  bit  m_fail [0:1];
  int  m_cnt  [0:1];
  bit  m_ffv  [0:1];
  int  m_ffa  [0:1];
  bit  m_done [0:1];
  int  m_i, m_j, m_lat, m_max;
  bit  m_rd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cyc = cyc - 1;
      for (int k = 0; k < 2; k++) begin
        m_fail[k] = 0; m_cnt[k] = 0; m_ffv[k] = 0; m_ffa[k] = 0; m_done[k] = 0;
      end
    end else begin
      m_i = cyc % 1024;
      ra[m_i] = cmp_addr;
      re[m_i] = exp_data;
      for (int k = 0; k < 2; k++) begin
        rv[k][m_i] = cmp_en && !m_done[k];
        rt[k][m_i] = test_done && !m_done[k];
      end
      if (clear) begin
        flush_cyc = cyc;
        for (int k = 0; k < 2; k++) begin
          m_fail[k] = 0; m_cnt[k] = 0; m_ffv[k] = 0; m_ffa[k] = 0; m_done[k] = 0;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          m_lat = (k == 0) ? 1 : 3;
          m_max = (k == 0) ? 255 : 7;
          m_rd  = (k == 0) ? rd_a : rd_b;
          m_j   = cyc - m_lat;
          if (m_j > flush_cyc) begin
            m_j = m_j % 1024;
            if (rv[k][m_j] && (m_rd != re[m_j])) begin
              m_fail[k] = 1;
              if (m_cnt[k] < m_max) m_cnt[k]++;
              if (!m_ffv[k]) begin
                m_ffv[k] = 1;
                m_ffa[k] = ra[m_j];
              end
            end
            if (rt[k][m_j]) m_done[k] = 1;
          end
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_fail", fail_a, m_fail[0]);
      chk("a_cnt",  cnt_a,  m_cnt[0]);
      chk("a_ffv",  ffv_a,  m_ffv[0]);
      chk("a_ffa",  ffa_a,  m_ffa[0]);
      chk("a_done", done_a, m_done[0]);
      chk("a_pass", pass_a, m_done[0] && !m_fail[0]);
      chk("b_fail", fail_b, m_fail[1]);
      chk("b_cnt",  cnt_b,  m_cnt[1]);
      chk("b_ffv",  ffv_b,  m_ffv[1]);
      chk("b_ffa",  ffa_b,  m_ffa[1]);
      chk("b_done", done_b, m_done[1]);
      chk("b_pass", pass_b, m_done[1] && !m_fail[1]);
    end
  end

  // Stimulus side: read data for each instance is scheduled at issue time.
  int t = 0;
  bit sa [0:1023];
  bit sb [0:1023];

  task automatic step(input bit en, input int addr, input bit ex, input bit fa,
                      input bit fb, input bit td, input bit clr);
    cmp_en    = en;
    cmp_addr  = addr[7:0];
    exp_data  = ex;
    test_done = td;
    clear     = clr;
    rd_a      = sa[t % 1024];
    rd_b      = sb[t % 1024];
    if (en) begin
      sa[(t + 1) % 1024] = ex ^ fa;
      sb[(t + 3) % 1024] = ex ^ fb;
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_clear();
    step(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_out"}, {fail_a, cnt_a, ffv_a, ffa_a, done_a, pass_a}, 0);
    chk({tag, "_b_out"}, {fail_b, cnt_b, ffv_b, ffa_b, done_b, pass_b}, 0);
  endtask

  initial begin
    rst_n = 1'b0; clear = 0; cmp_en = 0; cmp_addr = 0; exp_data = 0;
    rd_a = 0; rd_b = 0; test_done = 0;
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // All reads match; verdict lands RD_LAT+1 after test_done.
    for (int i = 0; i < 16; i++) step(1, i, i[0], 0, 0, i == 15, 0);
    chk("t1_a_done_early", done_a, 0);
    idle(1);
    chk("t1_a_done", done_a, 1);
    chk("t1_a_pass", pass_a, 1);
    chk("t1_b_done_early", done_b, 0);
    idle(2);
    chk("t1_b_pass", pass_b, 1);
    chk("t1_a_cnt", cnt_a, 0);
    chk("t1_a_ffv", ffv_a, 0);

    // Full address sweep with a single bad cell at 0x35.
    do_clear();
    for (int i = 0; i < 256; i++) begin
      step(1, i, i[1] ^ i[4], i == 'h35, i == 'h35, i == 255, 0);
      if (i == 'h35) chk("t2_a_fail_before", fail_a, 0);
      if (i == 'h36) chk("t2_a_fail_after", fail_a, 1);
    end
    idle(4);
    chk("t2_a_cnt", cnt_a, 1);
    chk("t2_a_ffa", ffa_a, 'h35);
    chk("t2_a_pass", pass_a, 0);
    chk("t2_a_done", done_a, 1);
    chk("t2_b_ffa", ffa_b, 'h35);

    // Two mismatches: first address sticks.
    do_clear();
    step(1, 'h12, 1, 1, 1, 0, 0);
    step(1, 'h20, 0, 0, 0, 0, 0);
    step(1, 'h80, 0, 1, 1, 0, 0);
    step(1, 'h81, 1, 0, 0, 1, 0);
    idle(4);
    chk("t3_a_cnt", cnt_a, 2);
    chk("t3_a_ffa", ffa_a, 'h12);
    chk("t3_b_ffa", ffa_b, 'h12);

    // Ten mismatches: 3-bit counter saturates at 7.
    do_clear();
    for (int i = 0; i < 10; i++) step(1, i, i[0], 1, 1, i == 9, 0);
    idle(4);
    chk("t4_a_cnt", cnt_a, 10);
    chk("t4_b_cnt", cnt_b, 7);
    chk("t4_b_fail", fail_b, 1);

    // Compare and tdone in the same slot; later reads ignored.
    do_clear();
    step(1, 'h44, 1, 1, 1, 1, 0);
    idle(2);
    chk("t5_b_cnt_early", cnt_b, 0);
    chk("t5_b_done_early", done_b, 0);
    idle(1);
    chk("t5_b_cnt", cnt_b, 1);
    chk("t5_b_done", done_b, 1);
    chk("t5_b_pass", pass_b, 0);
    for (int i = 0; i < 3; i++) step(1, 'h50 + i, 0, 1, 1, 0, 0);
    idle(4);
    chk("t5_a_cnt_hold", cnt_a, 1);
    chk("t5_b_cnt_hold", cnt_b, 1);

    // Clear with reads in flight discards them.
    do_clear();
    for (int i = 1; i <= 3; i++) step(1, i, 1, 1, 1, 0, 0);
    chk("t6_a_cnt_pre", cnt_a, 2);
    do_clear();
    chk_all_zero("t6_clear");
    idle(5);
    chk_all_zero("t6_after");

    // Asynchronous reset mid-run.
    for (int i = 0; i < 4; i++) step(1, 'h60 + i, 0, 1, 1, 0, 0);
    cmp_en = 0;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("t7_async");
    @(posedge clk);
    #1;
    t++;
    rst_n = 1'b1;

    // test_done with no reads at all.
    step(0, 0, 0, 0, 0, 1, 0);
    chk("t8_a_done_early", done_a, 0);
    idle(1);
    chk("t8_a_pass", pass_a, 1);
    idle(2);
    chk("t8_b_pass", pass_b, 1);
    idle(2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
